countdown_timer: RTL and testbench
==================================

# countdown_timer

Programmable down-counting timer; complements the free-running up `counter` by counting a loaded value down to zero and signalling expiry. Holds a reload register, divides `clk` by a programmable prescaler, and runs one-shot or periodic. Used as the timeout/interval source beside the up-counters in the same clock domain.

## Interface
- `WIDTH`, 4: count and reload width.
- `PRESCALE_W`, 4: prescaler compare width.

- `clk` in 1: clock, rising edge.
- `clr` in 1: reset, asynchronous, active-high.
- `load` in 1: write `load_val` into the reload register; also into `count` when not RUN.
- `load_val` in WIDTH: value captured on `load`.
- `prescale` in PRESCALE_W: tick every `prescale`+1 RUN cycles; 0 ticks every cycle.
- `periodic` in 1: 1 selects auto-reload on expiry; 0 selects one-shot.
- `start` in 1: IDLE→RUN, or HOLD→RUN.
- `stop` in 1: RUN→HOLD, or HOLD→IDLE.
- `count` out WIDTH: current count.
- `busy` out 1: high when state is RUN.
- `done` out 1: one-cycle expiry pulse.

## Operation
- States: IDLE, RUN, HOLD. Reset: IDLE, `count`=0, reload=0, prescaler=0, `busy`=0, `done`=0.
- IDLE: `start` with `count`≠0 → RUN, prescaler cleared. `start` with `count`=0 is ignored: no state change, no `done`.
- RUN: prescaler increments each cycle. When prescaler=`prescale`: tick, prescaler←0, `count` decrements.
- Tick with `count`=1, `periodic`=0: `count`←0, →IDLE, `done`=1.
- Tick with `count`=1, `periodic`=1, reload≠0: `count`←reload, stay RUN, `done`=1.
- Tick with `count`=1, `periodic`=1, reload=0: treated as one-shot.
- RUN + `stop` → HOLD; `count` and prescaler frozen.
- HOLD + `start` → RUN; prescaler resumes from its held value.
- HOLD + `stop` → IDLE; `count` retained.
- `load` in IDLE/HOLD: reload←`load_val` and `count`←`load_val`.
- `load` in RUN: reload only; `count` and state unaffected.
- Priority within a cycle: `stop` > `start`. `stop` in RUN suppresses that cycle's tick, so no `done`.
- `load` together with `start` in IDLE: `start` is evaluated against the pre-load `count`. Software loads first, then starts.
- `prescale` is sampled every cycle. Changing it mid-run takes effect at the next compare. If prescaler > new `prescale`, the prescaler wraps through 2^PRESCALE_W before the next tick.
- Arithmetic is unsigned. `count` never wraps below 0.

## Timing
- All outputs registered. `done` is high exactly in the first cycle that shows the post-expiry `count`.
- `start` sampled at the end of cycle N: `busy`=1 from cycle N+1.
- First decrement is visible in cycle N+2+P (P=`prescale`).
- One-shot from L: `count`=0, `done`=1, `busy`=0 in cycle N+1+L·(P+1).
- Periodic from L: `done` every L·(P+1) cycles, first at N+1+L·(P+1).
- `clr` mid-operation: all state returns to reset values immediately, asynchronously. An in-flight `done` is lost.

## Structure
- Package `timer_pkg`: state enum `timer_state_e` (IDLE, RUN, HOLD).
- Sub-module `tick_gen`: prescaler counter, compare, clear and hold inputs; outputs a one-cycle `tick`.
- Top level: FSM, reload register, count datapath.

## Test plan
- Reset: assert `clr` mid-RUN with `count`=7 → `count`=0, `busy`=0, `done`=0 at once; state IDLE.
- One-shot: load 3, P=0, `start` in cycle 0 → `count` shows 2,1,0 in cycles 2,3,4. `done`=1 only in cycle 4. `busy` falls in cycle 4.
- Prescaled periodic: load 2, P=2, `periodic`=1, start at cycle 0 → `done` pulses at cycles 7, 13, 19. `count` reloads to 2 on each.
- Hold/resume: load 5, P=1, `stop` mid-prescale. Hold 10 cycles, then `start` → `count` and prescaler unchanged across the hold. Total cycles to `done` = 11 + RUN cycles (expiry math excludes the hold).
- Edge cases:
  - `start` with `count`=0 → stays IDLE, no `done`.
  - `stop` and `start` together in RUN → HOLD.
  - `stop` on the terminal tick → HOLD, `count`=1, no `done`.
- Load in RUN: load 9 while running from 4 in periodic mode → `count` continues 3,2,1. Reload after expiry = 9.

Source files
------------

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types for the countdown timer
//
// Purpose: state encoding for the countdown_timer FSM.
// Ports:   none (package).
package timer_pkg;

  // IDLE: stopped, count may be loaded.
  // RUN:  counting down on prescaled ticks.
  // HOLD: paused, count and prescaler frozen.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } timer_state_e;

endpackage

// File: rtl/countdown_timer_tick_gen.sv
// rtl/countdown_timer_tick_gen.sv - prescaler that emits a tick every prescale+1 cycles
//
// Purpose: free-running prescale counter with compare against a live
//          prescale value; used by countdown_timer to pace decrements.
// Ports:
//   clk       in  clock, rising edge
//   clr       in  asynchronous active-high reset
//   clear     in  force prescaler to zero next cycle (wins over hold)
//   hold      in  freeze prescaler, suppress tick
//   prescale  in  compare value; tick when prescaler equals it
//   tick      out one-cycle tick (combinational from prescaler state)
module tick_gen #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  clear,
  input  logic                  hold,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] presc_q;
  logic [PRESCALE_W-1:0] presc_d;

  // The compare is an equality, so if prescale drops below the current
  // prescaler value the counter simply wraps through 2^PRESCALE_W before
  // it matches again.
  always_comb begin
    tick    = 1'b0;
    presc_d = presc_q;
    if (clear) begin
      presc_d = '0;
    end else if (!hold) begin
      if (presc_q == prescale) begin
        tick    = 1'b1;
        presc_d = '0;
      end else begin
        presc_d = presc_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - programmable one-shot / periodic down-counting timer
//
// Purpose: counts a loaded value down to zero on prescaled ticks and pulses
//          done on expiry; optionally reloads for periodic operation.
// Ports:
//   clk        in  clock, rising edge
//   clr        in  asynchronous active-high reset
//   load       in  capture load_val into reload (and count when not running)
//   load_val   in  value captured on load
//   prescale   in  tick every prescale+1 running cycles
//   periodic   in  1: auto-reload on expiry, 0: one-shot
//   start      in  IDLE->RUN (count must be nonzero) or HOLD->RUN
//   stop       in  RUN->HOLD or HOLD->IDLE; has priority over start
//   count      out current count (registered)
//   busy       out high while running (registered)
//   done       out one-cycle expiry pulse (registered)
module countdown_timer
  import timer_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  periodic,
  input  logic                  start,
  input  logic                  stop,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  done
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  timer_state_e     state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tick;

  // Prescaler sits at zero while IDLE so every start from IDLE begins a
  // fresh prescale period; in HOLD (or on a stop cycle) it is frozen.
  tick_gen #(
    .PRESCALE_W(PRESCALE_W)
  ) u_tick_gen (
    .clk      (clk),
    .clr      (clr),
    .clear    (state_q == IDLE),
    .hold     ((state_q != RUN) || stop),
    .prescale (prescale),
    .tick     (tick)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;

    // Loading while running only retargets the next reload.
    if (load) begin
      reload_d = load_val;
      if (state_q != RUN) begin
        count_d = load_val;
      end
    end

    unique case (state_q)
      IDLE: begin
        // Start is judged against the pre-load count.
        if (start && (count_q != '0)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = HOLD;
        end else if (tick) begin
          if (count_q > ONE) begin
            count_d = count_q - ONE;
          end else begin
            done_d = 1'b1;
            if (periodic && (reload_q != '0)) begin
              count_d = reload_q;
            end else begin
              count_d = '0;
              state_d = IDLE;
            end
          end
        end
      end
      HOLD: begin
        if (stop) begin
          state_d = IDLE;
        end else if (start) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - self-checking bench for countdown_timer
module tb_countdown_timer;

  localparam int W  = 4;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          clr;
  logic          load;
  logic [W-1:0]  load_val;
  logic [PW-1:0] prescale;
  logic          periodic;
  logic          start;
  logic          stop;
  logic [W-1:0]  count;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;

  // Reference model: plain integers and flags describing the timer.
  int m_cnt, m_rel, m_pre;
  bit m_run, m_hold, m_done;

  countdown_timer #(.WIDTH(W), .PRESCALE_W(PW)) dut (
    .clk      (clk),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .prescale (prescale),
    .periodic (periodic),
    .start    (start),
    .stop     (stop),
    .count    (count),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_cnt = 0; m_rel = 0; m_pre = 0;
    m_run = 0; m_hold = 0; m_done = 0;
  endtask

  // One clock: advance the model from the current inputs, clock the DUT,
  // then sample 1 time unit after the edge and drop the pulse inputs.
  task automatic cyc();
    int n_cnt, n_rel, n_pre;
    bit n_run, n_hold, n_done;
    n_cnt = m_cnt; n_rel = m_rel; n_pre = m_pre;
    n_run = m_run; n_hold = m_hold; n_done = 0;
    if (load) begin
      n_rel = int'(load_val);
      if (!m_run) n_cnt = int'(load_val);
    end
    if (m_run) begin
      if (stop) begin
        n_run = 0; n_hold = 1;
      end else if (m_pre == int'(prescale)) begin
        n_pre = 0;
        if (m_cnt > 1) n_cnt = m_cnt - 1;
        else begin
          n_done = 1;
          if (periodic && m_rel != 0) n_cnt = m_rel;
          else begin n_cnt = 0; n_run = 0; end
        end
      end else begin
        n_pre = (m_pre + 1) % (1 << PW);
      end
    end else if (m_hold) begin
      if (stop) begin n_hold = 0; n_pre = 0; end
      else if (start) begin n_hold = 0; n_run = 1; end
    end else begin
      n_pre = 0;
      if (start && m_cnt != 0) n_run = 1;
    end
    @(posedge clk);
    #1;
    m_cnt = n_cnt; m_rel = n_rel; m_pre = n_pre;
    m_run = n_run; m_hold = n_hold; m_done = n_done;
    load = 0; start = 0; stop = 0;
  endtask

  task automatic to_idle();
    stop = 1; cyc();
    stop = 1; cyc();
  endtask

  task automatic test_reset();
    clr = 1; load = 0; start = 0; stop = 0;
    load_val = '0; prescale = '0; periodic = 0;
    model_reset();
    #12;
    total++; if (count !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL reset_init got=%0d/%0b/%0b exp=0/0/0", count, busy, done);
    end
    clr = 0;
    @(posedge clk); #1;
    load = 1; load_val = 4'd7; prescale = 4'd3; cyc();
    start = 1; cyc();
    cyc();
    total++; if (count !== 4'd7 || busy !== 1'b1) begin
      bad++; $display("FAIL reset_prerun got=%0d/%0b exp=7/1", count, busy);
    end
    #2 clr = 1;
    #1;
    total++; if (count !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL reset_async got=%0d/%0b/%0b exp=0/0/0", count, busy, done);
    end
    #1 clr = 0;
    model_reset();
    @(posedge clk); #1;
    total++; if (busy !== 1'b0 || count !== 4'd0) begin
      bad++; $display("FAIL reset_idle got=%0d/%0b exp=0/0", count, busy);
    end
  endtask

  task automatic test_one_shot();
    logic [W-1:0] exp_c [1:5] = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd0};
    logic         exp_d [1:5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic         exp_b [1:5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    periodic = 0; prescale = 4'd0;
    load = 1; load_val = 4'd3; cyc();
    start = 1;
    for (int c = 1; c <= 5; c++) begin
      cyc();
      total++; if (count !== exp_c[c] || done !== exp_d[c] || busy !== exp_b[c]) begin
        bad++; $display("FAIL one_shot c%0d got=%0d/%0b/%0b exp=%0d/%0b/%0b",
                        c, count, done, busy, exp_c[c], exp_d[c], exp_b[c]);
      end
    end
  endtask

  task automatic test_periodic();
    bit exp_d;
    periodic = 1; prescale = 4'd2;
    load = 1; load_val = 4'd2; cyc();
    start = 1;
    for (int c = 1; c <= 20; c++) begin
      cyc();
      exp_d = (c == 7 || c == 13 || c == 19);
      total++; if (done !== exp_d || busy !== 1'b1) begin
        bad++; $display("FAIL periodic_done c%0d got=%0b/%0b exp=%0b/1", c, done, busy, exp_d);
      end
      if (exp_d) begin
        total++; if (count !== 4'd2) begin
          bad++; $display("FAIL periodic_reload c%0d got=%0d exp=2", c, count);
        end
      end
    end
    to_idle();
    periodic = 0;
  endtask

  task automatic test_hold_resume();
    prescale = 4'd1;
    load = 1; load_val = 4'd5; cyc();
    start = 1; cyc();
    cyc(); cyc(); cyc();          // now in cycle 4, prescaler mid-period
    total++; if (count !== 4'd4 || busy !== 1'b1) begin
      bad++; $display("FAIL hold_prestop got=%0d/%0b exp=4/1", count, busy);
    end
    stop = 1;
    for (int c = 5; c <= 14; c++) begin
      cyc();
      total++; if (count !== 4'd4 || busy !== 1'b0 || done !== 1'b0) begin
        bad++; $display("FAIL hold_frozen c%0d got=%0d/%0b/%0b exp=4/0/0", c, count, busy, done);
      end
    end
    start = 1;
    for (int c = 15; c <= 23; c++) begin
      cyc();
      total++; if (done !== (c == 22)) begin
        bad++; $display("FAIL hold_done c%0d got=%0b exp=%0b", c, done, (c == 22));
      end
      if (c == 16) begin
        total++; if (count !== 4'd3) begin
          bad++; $display("FAIL hold_resume_cnt got=%0d exp=3", count);
        end
      end
    end
  endtask

  task automatic test_edges();
    // count is 0 here: start must be ignored
    start = 1; cyc();
    total++; if (busy !== 1'b0 || done !== 1'b0 || count !== 4'd0) begin
      bad++; $display("FAIL start_zero got=%0d/%0b/%0b exp=0/0/0", count, busy, done);
    end
    prescale = 4'd0;
    load = 1; load_val = 4'd6; cyc();
    start = 1; cyc();
    stop = 1; start = 1; cyc();
    total++; if (busy !== 1'b0 || count !== 4'd6 || done !== 1'b0) begin
      bad++; $display("FAIL stop_start got=%0d/%0b/%0b exp=6/0/0", count, busy, done);
    end
    stop = 1; cyc();
    start = 1; cyc();
    total++; if (busy !== 1'b1 || count !== 4'd6) begin
      bad++; $display("FAIL idle_retain got=%0d/%0b exp=6/1", count, busy);
    end
    to_idle();
    load = 1; load_val = 4'd1; cyc();
    start = 1; cyc();
    stop = 1; cyc();
    total++; if (busy !== 1'b0 || count !== 4'd1 || done !== 1'b0) begin
      bad++; $display("FAIL stop_terminal got=%0d/%0b/%0b exp=1/0/0", count, busy, done);
    end
    stop = 1; cyc();
  endtask

  task automatic test_load_in_run();
    logic [W-1:0] exp_c [2:6] = '{4'd3, 4'd2, 4'd1, 4'd9, 4'd8};
    periodic = 1; prescale = 4'd0;
    load = 1; load_val = 4'd4; cyc();
    start = 1; cyc();
    load = 1; load_val = 4'd9;
    for (int c = 2; c <= 6; c++) begin
      cyc();
      total++; if (count !== exp_c[c] || done !== (c == 5) || busy !== 1'b1) begin
        bad++; $display("FAIL load_run c%0d got=%0d/%0b/%0b exp=%0d/%0b/1",
                        c, count, done, busy, exp_c[c], (c == 5));
      end
    end
    to_idle();
    periodic = 0;
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 600; i++) begin
      start    = ($urandom_range(0, 3) == 0);
      stop     = ($urandom_range(0, 7) == 0);
      load     = ($urandom_range(0, 5) == 0);
      load_val = W'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) periodic = ~periodic;
      if ($urandom_range(0, 15) == 0) prescale = PW'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) prescale = PW'($urandom_range(0, 15));
      cyc();
      total++; if (count !== W'(m_cnt) || busy !== m_run || done !== m_done) begin
        bad++;
        if (errs < 10)
          $display("FAIL random i%0d got=%0d/%0b/%0b exp=%0d/%0b/%0b",
                   i, count, busy, done, m_cnt, m_run, m_done);
        errs++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_periodic();
    test_hold_resume();
    test_edges();
    test_load_in_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
